// File: rtl/fft_mag_peak.sv
// Magnitude-squared post-processor for the FFT output stream: two-stage pipeline
// with per-bin index tags and an end-of-frame peak report.
module fft_mag_peak #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned BIN_W    = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAG_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_push,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              in_stall,
  output logic              out_push,
  output logic [MAG_W-1:0]  out_mag,
  output logic [BIN_W-1:0]  out_bin,
  input  logic              out_stall,
  output logic              peak_valid,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [MAG_W-1:0]  peak_mag
);

  localparam int unsigned SqW = 2 * DATA_W - 1;
  localparam logic [BIN_W-1:0] LastBin = BIN_W'(N_POINTS - 1);

  logic                      en;
  logic                      accept;
  logic signed [2*DATA_W-1:0] re_ext, im_ext;
  logic [SqW-1:0]            re_sq, im_sq;

  logic                      s1_valid_q;
  logic [SqW-1:0]            s1_re2_q, s1_im2_q;
  logic [BIN_W-1:0]          s1_bin_q;
  logic                      s2_valid_q;
  logic [MAG_W-1:0]          s2_mag_q;
  logic [BIN_W-1:0]          s2_bin_q;
  logic [BIN_W-1:0]          bin_cnt_q;

  logic [BIN_W-1:0]          run_bin_q;
  logic [MAG_W-1:0]          run_mag_q;
  logic                      peak_valid_q;
  logic [BIN_W-1:0]          peak_bin_q;
  logic [MAG_W-1:0]          peak_mag_q;

  logic                      xfer;
  logic                      take;
  logic                      last;

  assign en       = ~out_stall;
  assign accept   = in_push & en;
  assign in_stall = out_stall;

  // A square of a signed value is non-negative and fits in 2*DATA_W-1 bits.
  assign re_ext = (2 * DATA_W)'(signed'(in_real));
  assign im_ext = (2 * DATA_W)'(signed'(in_imag));
  assign re_sq  = SqW'(re_ext * re_ext);
  assign im_sq  = SqW'(im_ext * im_ext);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_re2_q   <= '0;
      s1_im2_q   <= '0;
      s1_bin_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_mag_q   <= '0;
      s2_bin_q   <= '0;
      bin_cnt_q  <= '0;
    end else if (en) begin
      s1_valid_q <= in_push;
      s1_re2_q   <= re_sq;
      s1_im2_q   <= im_sq;
      s1_bin_q   <= bin_cnt_q;
      s2_valid_q <= s1_valid_q;
      s2_mag_q   <= MAG_W'(s1_re2_q) + MAG_W'(s1_im2_q);
      s2_bin_q   <= s1_bin_q;
      if (accept) bin_cnt_q <= bin_cnt_q + 1'b1;
    end
  end

  assign xfer = s2_valid_q & ~out_stall;
  // Bin 0 always reloads; later bins need a strict win so ties keep the lower index.
  assign take = (s2_bin_q == '0) || (s2_mag_q > run_mag_q);
  assign last = (s2_bin_q == LastBin);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_bin_q    <= '0;
      run_mag_q    <= '0;
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      peak_valid_q <= xfer & last;
      if (xfer && take) begin
        run_bin_q <= s2_bin_q;
        run_mag_q <= s2_mag_q;
      end
      if (xfer && last) begin
        peak_bin_q <= take ? s2_bin_q : run_bin_q;
        peak_mag_q <= take ? s2_mag_q : run_mag_q;
      end
    end
  end

  assign out_push   = s2_valid_q;
  assign out_mag    = s2_mag_q;
  assign out_bin    = s2_bin_q;
  assign peak_valid = peak_valid_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;

endmodule

// File: tb/tb_fft_mag_peak.sv
// Scoreboard bench for fft_mag_peak: directed frames push expected bins/peaks into
// queues, independent monitors pop and compare on each output transfer and report.
module tb_fft_mag_peak;

  logic        clk;
  logic        reset;
  logic        in_push;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic        in_stall;
  logic        out_push;
  logic [31:0] out_mag;
  logic [3:0]  out_bin;
  logic        out_stall;
  logic        peak_valid;
  logic [3:0]  peak_bin;
  logic [31:0] peak_mag;

  typedef struct packed {
    logic [3:0]  bin;
    logic [31:0] mag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       pk_q[$];
  logic [3:0] nb;
  int         errors;
  int         checks;

  fft_mag_peak #(
    .N_POINTS(16),
    .BIN_W   (4),
    .DATA_W  (16),
    .MAG_W   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_push   (in_push),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .in_stall  (in_stall),
    .out_push  (out_push),
    .out_mag   (out_mag),
    .out_bin   (out_bin),
    .out_stall (out_stall),
    .peak_valid(peak_valid),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one bin, hold it until accepted, and queue its expected magnitude.
  task automatic send(input logic [15:0] re, input logic [15:0] im, input logic [31:0] mag);
    bit acc;
    int n;
    n       = 0;
    acc     = 1'b0;
    in_push = 1'b1;
    in_real = re;
    in_imag = im;
    exp_q.push_back({nb, mag});
    nb = nb + 4'd1;
    while (!acc && n < 50) begin
      acc = !in_stall;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept timeout", 64'd0, 64'd1);
    in_push = 1'b0;
  endtask

  task automatic exp_peak(input logic [3:0] b, input logic [31:0] m);
    pk_q.push_back({b, m});
  endtask

  // Monitor: compare on every output transfer and every peak pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (out_push && !out_stall) begin
        if (exp_q.size() == 0) chk("unexpected out_push", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_bin", 64'(out_bin), 64'(e.bin));
          chk("out_mag", 64'(out_mag), 64'(e.mag));
        end
      end
      if (peak_valid) begin
        if (pk_q.size() == 0) chk("unexpected peak_valid", 64'd1, 64'd0);
        else begin
          e = pk_q.pop_front();
          chk("peak_bin", 64'(peak_bin), 64'(e.bin));
          chk("peak_mag", 64'(peak_mag), 64'(e.mag));
        end
      end
    end
  end

  initial begin
    logic [31:0] sm;
    logic [3:0]  sb;
    int          w;
    errors    = 0;
    checks    = 0;
    nb        = 4'd0;
    reset     = 1'b0;
    in_push   = 1'b1;
    in_real   = 16'h1234;
    in_imag   = 16'h0042;
    out_stall = 1'b0;

    // Reset holds everything clear even with in_push asserted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_push", 64'(out_push), 64'd0);
    chk("rst peak_valid", 64'(peak_valid), 64'd0);
    chk("rst out_mag", 64'(out_mag), 64'd0);
    chk("rst peak_bin", 64'(peak_bin), 64'd0);
    chk("rst peak_mag", 64'(peak_mag), 64'd0);
    out_stall = 1'b1;
    #1;
    chk("in_stall follows 1", 64'(in_stall), 64'd1);
    out_stall = 1'b0;
    #1;
    chk("in_stall follows 0", 64'(in_stall), 64'd0);
    in_push = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, with latency probe.
    for (int k = 0; k < 16; k++) begin
      send(16'(100 * k), 16'd0, 32'(10000 * k * k));
      if (k == 0) chk("latency 1 cycle", 64'(out_push), 64'd0);
      if (k == 1) chk("latency 2 cycles", 64'(out_push), 64'd1);
    end
    exp_peak(4'd15, 32'd2250000);

    // Extremes, back-to-back with the ramp frame.
    send(16'h8000, 16'h8000, 32'h8000_0000);
    send(16'h7fff, 16'h0000, 32'h3FFF_0001);
    for (int k = 2; k < 16; k++) send(16'd0, 16'd0, 32'd0);
    exp_peak(4'd0, 32'h8000_0000);

    // Tie: equal peaks at bins 3 and 9.
    for (int k = 0; k < 16; k++) begin
      if (k == 3 || k == 9) send(16'd1000, 16'd0, 32'd1000000);
      else send(16'd0, 16'd0, 32'd0);
    end
    exp_peak(4'd3, 32'd1000000);

    // Backpressure: 3-cycle stall mid-frame, peak at bin 11.
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        sm        = out_mag;
        sb        = out_bin;
        in_push   = 1'b1;
        in_real   = 16'd8;
        in_imag   = 16'd0;
        out_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
          #1;
          chk("stall in_stall", 64'(in_stall), 64'd1);
          @(posedge clk);
          #1;
          chk("stall out_mag held", 64'(out_mag), 64'(sm));
          chk("stall out_bin held", 64'(out_bin), 64'(sb));
        end
        out_stall = 1'b0;
      end
      if (k == 11) send(16'd50, 16'd0, 32'd2500);
      else send(16'(k), 16'd0, 32'(k * k));
    end
    exp_peak(4'd11, 32'd2500);

    // Reset mid-frame: partial frame dropped, no report for it.
    for (int k = 0; k < 7; k++) send(16'(k + 1), 16'd0, 32'((k + 1) * (k + 1)));
    reset = 1'b0;
    exp_q.delete();
    nb = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) send(16'd300, 16'd400, 32'd250000);
      else send(16'd0, 16'd0, 32'd0);
    end
    exp_peak(4'd5, 32'd250000);

    w = 0;
    while ((exp_q.size() != 0 || pk_q.size() != 0) && w < 40) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("scoreboard drained", 64'(exp_q.size() + pk_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("peak_bin held", 64'(peak_bin), 64'd5);
    chk("peak_mag held", 64'(peak_mag), 64'd250000);
    chk("peak_valid idle", 64'(peak_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_mag_peak.md
Name: fft_mag_peak

Overview:
- Streaming post-processor placed directly downstream of fft_top.
- Consumes fft_top's push/stall output stream of N_POINTS complex bins per frame and emits a per-bin magnitude-squared stream, tagged with the bin index.
- At the end of each frame it reports the peak bin and its magnitude.
- Provides the spectral-peak readout for the 16-point, 16-bit FFT core.

Parameters:
- N_POINTS, 16, bins per frame (power of two).
- BIN_W, 4, log2(N_POINTS); width of bin indices.
- DATA_W, 16, signed two's-complement width of in_real and in_imag.
- MAG_W, 32, unsigned magnitude width; must equal 2*DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_push  input  1  input bin valid; connects to fft_top out_push_F.
- in_real  input  DATA_W  signed real part of the bin.
- in_imag  input  DATA_W  signed imaginary part of the bin.
- in_stall  output  1  backpressure to fft_top (out_stall).
- out_push  output  1  magnitude output valid.
- out_mag  output  MAG_W  unsigned in_real^2 + in_imag^2.
- out_bin  output  BIN_W  bin index of out_mag, in arrival order within the frame.
- out_stall  input  1  downstream backpressure.
- peak_valid  output  1  one-cycle pulse announcing that a frame's peak report is ready.
- peak_bin  output  BIN_W  index of the largest magnitude in the last completed frame.
- peak_mag  output  MAG_W  magnitude of that bin.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline valid bits, data registers, bin counter and running peak clear to 0; every output is 0.
- Handshake:
  - in_stall = out_stall, combinational.
  - An input is accepted on a clock edge where in_push=1 and in_stall=0.
  - An output is transferred on a clock edge where out_push=1 and out_stall=0.
- Pipeline:
  - Two register stages, both enabled only when out_stall=0. With out_stall=1 every stage holds, including valid bits and data.
  - Stage 1 registers: real^2, imag^2 (each unsigned, 2*DATA_W-1 bits), valid = in_push, and the bin tag.
  - Stage 2 registers: the sum (MAG_W bits), the tag, and the valid bit.
  - out_push is the stage-2 valid bit.
  - Latency is 2 cycles from acceptance to out_push, with no stalls. Throughput is 1 bin/cycle.
- Arithmetic:
  - Full-precision sum; no rounding, truncation or saturation.
  - Maximum value: (-2^15)^2 * 2 = 2^31, which fits in 32 bits.
- Bin counter (BIN_W bits):
  - Tags each accepted input, then increments.
  - Wraps from N_POINTS-1 to 0, which marks the frame boundary.
  - No idle timeout; a partial frame persists until it is completed or reset is asserted.
- Peak tracking (on output transfers only):
  - For bin 0: load the running peak with {out_bin, out_mag} unconditionally.
  - For other bins: replace the running peak only if out_mag is strictly greater than it. Ties keep the lowest index.
- Peak report:
  - On the edge that transfers bin N_POINTS-1, peak_bin and peak_mag load the final peak, and peak_valid=1 for exactly the following cycle.
  - The report is not subject to out_stall.
  - peak_bin and peak_mag hold until the next report.
- Simultaneous events: a back-to-back frame (bin 0 of the next frame accepted while bin N_POINTS-1 transfers) is handled without a bubble. The report snapshot is taken before the running peak is reloaded.
- Reset mid-frame: the partial frame is discarded, the counter restarts at 0, and no peak_valid is issued for the aborted frame.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with in_push=1 -> out_push=0, peak_valid=0, out_mag=0, peak_bin=0, peak_mag=0, in_stall=out_stall.
- Ramp frame: bins k=0..15 with real=100*k, imag=0, no stalls. Required response:
  - out_push rises 2 cycles after the first accept.
  - out_mag = 10000*k^2 with out_bin=k.
  - peak_valid pulses once, with peak_bin=15 and peak_mag=2250000.
- Extremes: real=imag=-32768 (0x8000) -> out_mag=0x80000000. Then real=0x7fff, imag=0 -> out_mag=0x3FFF0001.
- Tie rule: all bins 0 except bins 3 and 9, each 1000+i*0 -> peak_bin=3, peak_mag=1000000.
- Backpressure: assert out_stall for 3 cycles mid-frame -> in_stall high for the same 3 cycles, and out_mag/out_bin held stable. All 16 bins are delivered once, in order, and the peak report is correct.
- Reset mid-frame: accept 7 bins, pulse reset low, then send a full frame with bin 5 = 300+i*400 and all others 0 -> no report for the aborted frame, out_bin restarts at 0, peak_bin=5, peak_mag=250000.
